// File: rtl/led_pio_blink_pwm_if.sv
// Avalon-MM slave bus bundle for the LED output port.
// The master drives address/strobes/write data; the slave returns combinational read data.
interface led_pio_blink_pwm_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_pio_blink_pwm.sv
// LED output port with set/clear aliases, per-channel blink and a global brightness gate.
// Define LED_PWM_EN to build the 255-cycle PWM frame counter and the DUTY register.
module led_pio_blink_pwm #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      PERIOD_W    = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  led_pio_blink_pwm_if.slave avs,
  output logic [WIDTH-1:0]   o_out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_DUTY   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_mask;
  logic [WIDTH-1:0]    r_out;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_blink_cnt;
  logic                r_blink_phase;

  logic                w_wr;
  logic                w_period_wr;
  logic                w_blink_tc;
  logic                w_pwm_on;
  logic [7:0]          w_duty;
  logic [WIDTH-1:0]    w_wdata;
  logic [PERIOD_W-1:0] w_wperiod;
  logic [WIDTH-1:0]    w_en;
  logic                w_unused;

  assign w_wr        = avs.chipselect & ~avs.write_n;
  assign w_period_wr = w_wr && (avs.address == ADDR_PERIOD);
  assign w_wdata     = avs.writedata[WIDTH-1:0];
  assign w_wperiod   = avs.writedata[PERIOD_W-1:0];
  // Write data above each register's width is intentionally dropped.
  assign w_unused    = ^avs.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
    end else if (w_wr) begin
      case (avs.address)
        ADDR_DATA:  r_data <= w_wdata;
        ADDR_SET:   r_data <= r_data | w_wdata;
        ADDR_CLEAR: r_data <= r_data & ~w_wdata;
        default:    r_data <= r_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wr && (avs.address == ADDR_MASK)) begin
      r_mask <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= '0;
    end else if (w_period_wr) begin
      r_period <= w_wperiod;
    end
  end

  assign w_blink_tc = (r_blink_cnt == (r_period - PERIOD_W'(1)));

  // A period write restarts the half-period and outranks a coincident terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_period_wr || (r_period == '0)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_blink_tc) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + PERIOD_W'(1);
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] r_duty;
  logic [7:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty <= 8'hFF;
    end else if (w_wr && (avs.address == ADDR_DUTY)) begin
      r_duty <= avs.writedata[7:0];
    end
  end

  // 255-cycle frame so DUTY=255 is fully on and DUTY=0 fully off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt == 8'd254) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  assign w_pwm_on = (r_pwm_cnt < r_duty);
  assign w_duty   = r_duty;
`else
  assign w_pwm_on = 1'b1;
  assign w_duty   = 8'h00;
`endif

  assign w_en = r_data & (~r_mask | {WIDTH{r_blink_phase}}) & {WIDTH{w_pwm_on}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_en;
    end
  end

  assign o_out_port = r_out;

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: avs.readdata[WIDTH-1:0]    = r_data;
      ADDR_MASK:                       avs.readdata[WIDTH-1:0]    = r_mask;
      ADDR_PERIOD:                     avs.readdata[PERIOD_W-1:0] = r_period;
      ADDR_DUTY:                       avs.readdata[7:0]          = w_duty;
      ADDR_STATUS:                     avs.readdata[1:0]          = {w_pwm_on, r_blink_phase};
      default:                         avs.readdata               = '0;
    endcase
  end

endmodule
